// File: rtl/cv32e40p_tmr_pkg.sv
// Shared types and constants for the TMR fault manager: FSM state encoding,
// replica indices, the resync settle length and small replica-set helpers.
package cv32e40p_tmr_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    SETTLE = 2'd2,
    FAULT  = 2'd3
  } tmr_state_e;

  localparam logic [1:0] REPLICA_A = 2'd0;
  localparam logic [1:0] REPLICA_B = 2'd1;
  localparam logic [1:0] REPLICA_C = 2'd2;

  // Quiet cycles between an acknowledged resync and the next request.
  localparam int unsigned SETTLE_CYCLES = 2;
  localparam int unsigned SETTLE_W      = 1;

  // Lowest-index member of a replica set (A wins over B wins over C).
  function automatic logic [1:0] lowest_replica(input logic [2:0] set);
    logic [1:0] id;
    if (set[0]) begin
      id = REPLICA_A;
    end else if (set[1]) begin
      id = REPLICA_B;
    end else begin
      id = REPLICA_C;
    end
    return id;
  endfunction

  // One-hot replica mask for a replica index.
  function automatic logic [2:0] replica_onehot(input logic [1:0] id);
    logic [2:0] mask;
    case (id)
      REPLICA_A: mask = 3'b001;
      REPLICA_B: mask = 3'b010;
      REPLICA_C: mask = 3'b100;
      default:   mask = 3'b000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/cv32e40p_tmr_replica_monitor.sv
// Per-replica fault bookkeeping: ORs the voter mismatch flags into a hit,
// keeps a saturating lifetime hit count, a per-window hit count and a sticky
// permanent-fault flag that sets once the window count reaches THRESH.
module cv32e40p_tmr_replica_monitor
  import cv32e40p_tmr_pkg::*;
#(
  parameter int unsigned NVOTERS = 8,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned THRESH  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NVOTERS-1:0] err_i,
  input  logic               clear_i,
  input  logic               wrap_i,
  output logic               hit_o,
  output logic [CNT_W-1:0]   cnt_o,
  output logic               perm_o,
  output logic               perm_next_o
);

  localparam int unsigned    WH_W     = $clog2(THRESH + 1);
  localparam logic [WH_W-1:0] THRESH_C = WH_W'(THRESH);

  logic               hit;
  logic               hit_eff;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WH_W-1:0]    whit_q, whit_d, whit_base;
  logic               perm_q, perm_d;

  assign hit     = |err_i;
  // A software clear swallows the hits of its own cycle everywhere.
  assign hit_eff = hit & ~clear_i;

  // Next-state for the lifetime counter, window count and sticky flag.
  always_comb begin
    cnt_d = cnt_q;
    if (hit_eff && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // The wrap cycle already belongs to the new window.
    whit_base = wrap_i ? '0 : whit_q;
    whit_d    = whit_base;
    if (hit_eff && (whit_base != THRESH_C)) begin
      whit_d = whit_base + WH_W'(1);
    end
    perm_d = perm_q | (whit_d == THRESH_C);
    if (clear_i) begin
      whit_d = '0;
      perm_d = 1'b0;
    end
  end

  // Register the counters and flag; only rst clears the lifetime count.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      whit_q <= '0;
      perm_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      whit_q <= whit_d;
      perm_q <= perm_d;
    end
  end

  assign hit_o       = hit;
  assign cnt_o       = cnt_q;
  assign perm_o      = perm_q;
  assign perm_next_o = perm_d;

endmodule

// File: rtl/cv32e40p_tmr_fault_manager.sv
// TMR fault manager: aggregates voter mismatch flags per replica, runs the
// observation window, issues resync requests for transient single-replica
// faults and escalates permanent and multi-replica faults.
//
// Handshake: resync_req_o rises with replica_id_o valid and both stay stable
// until resync_ack_i is sampled high while requesting; the request then drops
// on the next edge. A multi-replica hit or rst withdraws the request without
// an ack. resync_ack_i is ignored whenever no request is open.
module cv32e40p_tmr_fault_manager
  import cv32e40p_tmr_pkg::*;
#(
  parameter int unsigned NVOTERS = 8,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned WINDOW  = 1024,
  parameter int unsigned THRESH  = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NVOTERS-1:0] err_a_i,
  input  logic [NVOTERS-1:0] err_b_i,
  input  logic [NVOTERS-1:0] err_c_i,
  input  logic               clear_i,
  input  logic               resync_ack_i,
  output logic               resync_req_o,
  output logic [1:0]         replica_id_o,
  output logic [2:0]         perm_fault_o,
  output logic               multi_fault_o,
  output logic [CNT_W-1:0]   err_cnt_a_o,
  output logic [CNT_W-1:0]   err_cnt_b_o,
  output logic [CNT_W-1:0]   err_cnt_c_o,
  output logic               irq_o
);

  localparam int unsigned       WIN_W       = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WIN_W-1:0]  WIN_LAST    = WIN_W'(WINDOW - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  logic [NVOTERS-1:0]  err_arr [3];
  logic [CNT_W-1:0]    cnt_arr [3];
  logic [2:0]          hit;
  logic [2:0]          perm_q;
  logic [2:0]          perm_next;

  logic [WIN_W-1:0]    win_q, win_d;
  logic                wrap;

  tmr_state_e          state_q, state_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [2:0]          pend_q, pend_d;
  logic                req_q, req_d;
  logic [1:0]          id_q, id_d;
  logic                multi_q, multi_d;
  logic                irq_q, irq_d;

  logic                multi_hit;
  logic                single_hit;
  logic [2:0]          new_set;
  logic [2:0]          serve;
  logic [1:0]          serve_id;

  assign err_arr[0] = err_a_i;
  assign err_arr[1] = err_b_i;
  assign err_arr[2] = err_c_i;

  for (genvar g = 0; g < 3; g++) begin : g_mon
    cv32e40p_tmr_replica_monitor #(
      .NVOTERS (NVOTERS),
      .CNT_W   (CNT_W),
      .THRESH  (THRESH)
    ) u_mon (
      .clk         (clk),
      .rst         (rst),
      .err_i       (err_arr[g]),
      .clear_i     (clear_i),
      .wrap_i      (wrap),
      .hit_o       (hit[g]),
      .cnt_o       (cnt_arr[g]),
      .perm_o      (perm_q[g]),
      .perm_next_o (perm_next[g])
    );
  end

  // Free-running observation window position.
  assign wrap  = (win_q == WIN_LAST);
  assign win_d = wrap ? '0 : win_q + WIN_W'(1);

  // Classify this cycle's hits; a clear in the same cycle masks them all.
  always_comb begin
    multi_hit  = ~clear_i & ((hit[0] & hit[1]) | (hit[0] & hit[2]) | (hit[1] & hit[2]));
    single_hit = ~clear_i & (^hit) & ~((hit[0] & hit[1]) | (hit[0] & hit[2]) | (hit[1] & hit[2]));
    new_set    = single_hit ? (hit & ~perm_q) : 3'b000;
  end

  // Resync FSM: request, settle, pending-set service and fault lockout.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    pend_d   = clear_i ? 3'b000 : pend_q;
    req_d    = req_q;
    id_d     = id_q;
    serve    = 3'b000;
    serve_id = REPLICA_A;
    case (state_q)
      IDLE: begin
        if (multi_hit) begin
          state_d = FAULT;
          pend_d  = 3'b000;
        end else if (new_set != 3'b000) begin
          state_d = REQ;
          req_d   = 1'b1;
          id_d    = lowest_replica(new_set);
        end
      end
      REQ: begin
        if (multi_hit) begin
          state_d = FAULT;
          req_d   = 1'b0;
          pend_d  = 3'b000;
        end else begin
          pend_d = pend_d | new_set;
          if (resync_ack_i) begin
            state_d  = SETTLE;
            req_d    = 1'b0;
            settle_d = '0;
          end
        end
      end
      SETTLE: begin
        if (multi_hit) begin
          state_d = FAULT;
          pend_d  = 3'b000;
        end else if (settle_q == SETTLE_LAST) begin
          // Replicas that went permanent meanwhile are dropped, not served.
          serve    = (pend_d | new_set) & ~perm_q;
          serve_id = lowest_replica(serve);
          if (serve != 3'b000) begin
            state_d = REQ;
            req_d   = 1'b1;
            id_d    = serve_id;
            pend_d  = serve & ~replica_onehot(serve_id);
          end else begin
            state_d = IDLE;
            pend_d  = 3'b000;
          end
        end else begin
          settle_d = settle_q + SETTLE_W'(1);
          pend_d   = pend_d | new_set;
        end
      end
      FAULT: begin
        if (clear_i) begin
          state_d = IDLE;
          pend_d  = 3'b000;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
        pend_d  = 3'b000;
      end
    endcase
  end

  // Sticky multi-fault flag and the interrupt derived from next-state flags.
  always_comb begin
    multi_d = clear_i ? 1'b0 : (multi_q | multi_hit);
    irq_d   = (|perm_next) | multi_d;
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q    <= '0;
      state_q  <= IDLE;
      settle_q <= '0;
      pend_q   <= 3'b000;
      req_q    <= 1'b0;
      id_q     <= REPLICA_A;
      multi_q  <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      win_q    <= win_d;
      state_q  <= state_d;
      settle_q <= settle_d;
      pend_q   <= pend_d;
      req_q    <= req_d;
      id_q     <= id_d;
      multi_q  <= multi_d;
      irq_q    <= irq_d;
    end
  end

  assign resync_req_o  = req_q;
  assign replica_id_o  = id_q;
  assign perm_fault_o  = perm_q;
  assign multi_fault_o = multi_q;
  assign err_cnt_a_o   = cnt_arr[0];
  assign err_cnt_b_o   = cnt_arr[1];
  assign err_cnt_c_o   = cnt_arr[2];
  assign irq_o         = irq_q;

endmodule

// File: tb/tb_cv32e40p_tmr_fault_manager.sv
// Bench for cv32e40p_tmr_fault_manager: directed vector table, hand-written
// window/threshold/saturation/reset sequences and a randomized run, all
// scored against a behavioural model of the fault manager.
module tb_cv32e40p_tmr_fault_manager;

  localparam int NV   = 8;
  localparam int CW   = 8;
  localparam int WIN  = 1024;
  localparam int TH   = 4;
  localparam int CMAX = (1 << CW) - 1;
  localparam int OW   = 8 + 3 * CW;

  localparam int M_IDLE   = 0;
  localparam int M_REQ    = 1;
  localparam int M_SETTLE = 2;
  localparam int M_FAULT  = 3;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic [NV-1:0] err_a, err_b, err_c;
  logic          clear, ack;
  logic          resync_req;
  logic [1:0]    replica_id;
  logic [2:0]    perm_fault;
  logic          multi_fault;
  logic [CW-1:0] cnt_a, cnt_b, cnt_c;
  logic          irq;

  always #5 clk = ~clk;

  cv32e40p_tmr_fault_manager #(
    .NVOTERS (NV),
    .CNT_W   (CW),
    .WINDOW  (WIN),
    .THRESH  (TH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .err_a_i       (err_a),
    .err_b_i       (err_b),
    .err_c_i       (err_c),
    .clear_i       (clear),
    .resync_ack_i  (ack),
    .resync_req_o  (resync_req),
    .replica_id_o  (replica_id),
    .perm_fault_o  (perm_fault),
    .multi_fault_o (multi_fault),
    .err_cnt_a_o   (cnt_a),
    .err_cnt_b_o   (cnt_b),
    .err_cnt_c_o   (cnt_c),
    .irq_o         (irq)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [OW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [OW-1:0] dut_word();
    return {resync_req, replica_id, perm_fault, multi_fault, irq, cnt_a, cnt_b, cnt_c};
  endfunction

  // ---------------- behavioural model ----------------
  int m_tot[3];
  int m_wcnt[3];
  bit m_perm[3];
  bit m_pend[3];
  bit m_multi;
  bit m_req;
  int m_id;
  int m_mode;
  int m_settle_left;
  int m_cycle;

  task automatic model_reset();
    for (int r = 0; r < 3; r++) begin
      m_tot[r] = 0; m_wcnt[r] = 0; m_perm[r] = 0; m_pend[r] = 0;
    end
    m_multi = 0; m_req = 0; m_id = 0; m_mode = M_IDLE;
    m_settle_left = 0; m_cycle = 0;
  endtask

  task automatic model_step(input logic [2:0] hits, input bit clr, input bit ak);
    bit perm_old[3];
    int nh;
    bit wrap, is_multi, is_single;
    int newr, chosen;
    wrap = ((m_cycle % WIN) == WIN - 1);
    perm_old = m_perm;
    nh = int'(hits[0]) + int'(hits[1]) + int'(hits[2]);
    for (int r = 0; r < 3; r++) begin
      if (clr) begin
        m_wcnt[r] = 0;
        m_perm[r] = 0;
      end else begin
        if (wrap) m_wcnt[r] = 0;
        if (hits[r]) begin
          if (m_tot[r] < CMAX) m_tot[r]++;
          m_wcnt[r]++;
        end
        if (m_wcnt[r] >= TH) m_perm[r] = 1;
      end
    end
    is_multi  = !clr && (nh >= 2);
    is_single = !clr && (nh == 1);
    if (clr) m_multi = 0;
    else if (is_multi) m_multi = 1;
    newr = -1;
    if (is_single) begin
      for (int r = 0; r < 3; r++) if (hits[r] && !perm_old[r]) newr = r;
    end
    if (clr) for (int r = 0; r < 3; r++) m_pend[r] = 0;
    case (m_mode)
      M_IDLE: begin
        if (is_multi) begin
          m_mode = M_FAULT;
        end else if (newr >= 0) begin
          m_mode = M_REQ; m_req = 1; m_id = newr;
        end
      end
      M_REQ: begin
        if (is_multi) begin
          m_mode = M_FAULT; m_req = 0;
          for (int r = 0; r < 3; r++) m_pend[r] = 0;
        end else begin
          if (newr >= 0) m_pend[newr] = 1;
          if (ak) begin
            m_mode = M_SETTLE; m_req = 0; m_settle_left = 2;
          end
        end
      end
      M_SETTLE: begin
        if (is_multi) begin
          m_mode = M_FAULT;
          for (int r = 0; r < 3; r++) m_pend[r] = 0;
        end else begin
          if (newr >= 0) m_pend[newr] = 1;
          if (m_settle_left == 1) begin
            chosen = -1;
            for (int r = 2; r >= 0; r--) if (m_pend[r] && !perm_old[r]) chosen = r;
            if (chosen >= 0) begin
              m_mode = M_REQ; m_req = 1; m_id = chosen;
              for (int r = 0; r < 3; r++) if (r == chosen || perm_old[r]) m_pend[r] = 0;
            end else begin
              m_mode = M_IDLE;
              for (int r = 0; r < 3; r++) m_pend[r] = 0;
            end
          end else begin
            m_settle_left--;
          end
        end
      end
      default: begin
        if (clr) begin
          m_mode = M_IDLE;
          for (int r = 0; r < 3; r++) m_pend[r] = 0;
        end
      end
    endcase
    m_cycle++;
  endtask

  function automatic logic [OW-1:0] model_word();
    logic irq_m;
    irq_m = m_multi | m_perm[0] | m_perm[1] | m_perm[2];
    return {m_req, 2'(m_id), m_perm[2], m_perm[1], m_perm[0], m_multi, irq_m,
            CW'(m_tot[0]), CW'(m_tot[1]), CW'(m_tot[2])};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic [NV-1:0] a, input logic [NV-1:0] b, input logic [NV-1:0] c,
                        input logic clr, input logic ak);
    err_a = a; err_b = b; err_c = c; clear = clr; ack = ak;
  endtask

  task automatic set_idle();
    set_in('0, '0, '0, 1'b0, 1'b0);
  endtask

  // One clock: advance the model with the applied inputs, then score the DUT.
  task automatic tick();
    if (rst) model_reset();
    else model_step({|err_c, |err_b, |err_a}, clear, ack);
    exp_q.push_back(model_word());
    @(posedge clk);
    #1;
    check("model", 32'(dut_word()), 32'(exp_q.pop_front()));
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Single-cycle hit on one replica, acked on the following cycle, then settle.
  task automatic do_hit_ack(input int r);
    logic [NV-1:0] bitv;
    bitv = NV'(1) << $urandom_range(NV - 1, 0);
    set_in((r == 0) ? bitv : '0, (r == 1) ? bitv : '0, (r == 2) ? bitv : '0, 1'b0, 1'b0);
    tick();
    set_in('0, '0, '0, 1'b0, 1'b1);
    tick();
    set_idle();
    tick();
    tick();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [NV-1:0] a, b, c;
    logic          clr, ak;
    logic          req;
    logic [1:0]    id;
    logic [2:0]    perm;
    logic          multi, irq;
    logic [CW-1:0] ca, cb, cc;
  } vec_t;

  function automatic vec_t mkv(input logic [NV-1:0] a, input logic [NV-1:0] b, input logic [NV-1:0] c,
                               input logic clr, input logic ak, input logic req, input logic [1:0] id,
                               input logic [2:0] perm, input logic multi, input logic irq_e,
                               input logic [CW-1:0] ca, input logic [CW-1:0] cb, input logic [CW-1:0] cc);
    vec_t v;
    v.a = a; v.b = b; v.c = c; v.clr = clr; v.ak = ak; v.req = req; v.id = id;
    v.perm = perm; v.multi = multi; v.irq = irq_e; v.ca = ca; v.cb = cb; v.cc = cc;
    return v;
  endfunction

  vec_t vecs[18];

  initial begin
    logic [NV-1:0] bitv;
    int            rate;
    bit            idle_ok;

    // B hit, ack, settle; A+C multi hit and clear; A request with C pending;
    // clear during SETTLE swallows a B hit.
    vecs[0]  = mkv(8'h00, 8'h04, 8'h00, 0, 0, 1, 2'd1, 3'b000, 0, 0, 8'd0, 8'd1, 8'd0);
    vecs[1]  = mkv(8'h00, 8'h00, 8'h00, 0, 0, 1, 2'd1, 3'b000, 0, 0, 8'd0, 8'd1, 8'd0);
    vecs[2]  = mkv(8'h00, 8'h00, 8'h00, 0, 0, 1, 2'd1, 3'b000, 0, 0, 8'd0, 8'd1, 8'd0);
    vecs[3]  = mkv(8'h00, 8'h00, 8'h00, 0, 1, 0, 2'd1, 3'b000, 0, 0, 8'd0, 8'd1, 8'd0);
    vecs[4]  = mkv(8'h00, 8'h00, 8'h00, 0, 0, 0, 2'd1, 3'b000, 0, 0, 8'd0, 8'd1, 8'd0);
    vecs[5]  = mkv(8'h00, 8'h00, 8'h00, 0, 0, 0, 2'd1, 3'b000, 0, 0, 8'd0, 8'd1, 8'd0);
    vecs[6]  = mkv(8'h01, 8'h00, 8'h80, 0, 0, 0, 2'd1, 3'b000, 1, 1, 8'd1, 8'd1, 8'd1);
    vecs[7]  = mkv(8'h00, 8'h00, 8'h00, 0, 1, 0, 2'd1, 3'b000, 1, 1, 8'd1, 8'd1, 8'd1);
    vecs[8]  = mkv(8'h00, 8'h00, 8'h00, 1, 0, 0, 2'd1, 3'b000, 0, 0, 8'd1, 8'd1, 8'd1);
    vecs[9]  = mkv(8'h02, 8'h00, 8'h00, 0, 0, 1, 2'd0, 3'b000, 0, 0, 8'd2, 8'd1, 8'd1);
    vecs[10] = mkv(8'h00, 8'h00, 8'h01, 0, 0, 1, 2'd0, 3'b000, 0, 0, 8'd2, 8'd1, 8'd2);
    vecs[11] = mkv(8'h00, 8'h00, 8'h00, 0, 1, 0, 2'd0, 3'b000, 0, 0, 8'd2, 8'd1, 8'd2);
    vecs[12] = mkv(8'h00, 8'h00, 8'h00, 0, 0, 0, 2'd0, 3'b000, 0, 0, 8'd2, 8'd1, 8'd2);
    vecs[13] = mkv(8'h00, 8'h00, 8'h00, 0, 0, 1, 2'd2, 3'b000, 0, 0, 8'd2, 8'd1, 8'd2);
    vecs[14] = mkv(8'h00, 8'h00, 8'h00, 0, 1, 0, 2'd2, 3'b000, 0, 0, 8'd2, 8'd1, 8'd2);
    vecs[15] = mkv(8'h00, 8'h08, 8'h00, 1, 0, 0, 2'd2, 3'b000, 0, 0, 8'd2, 8'd1, 8'd2);
    vecs[16] = mkv(8'h00, 8'h00, 8'h00, 0, 0, 0, 2'd2, 3'b000, 0, 0, 8'd2, 8'd1, 8'd2);
    vecs[17] = mkv(8'h00, 8'h00, 8'h00, 0, 0, 0, 2'd2, 3'b000, 0, 0, 8'd2, 8'd1, 8'd2);

    rst = 1'b1;
    set_idle();

    // Reset state and a long quiet run.
    do_reset();
    check("reset_outputs", 32'(dut_word()), 32'd0);
    idle_ok = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (resync_req !== 1'b0) idle_ok = 1'b0;
    end
    check("idle_no_req", 32'(idle_ok), 32'd1);
    check("idle_outputs", 32'(dut_word()), 32'd0);

    // Directed table.
    do_reset();
    for (int i = 0; i < 18; i++) begin
      set_in(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].clr, vecs[i].ak);
      tick();
      check($sformatf("vec%0d", i), 32'(dut_word()),
            32'({vecs[i].req, vecs[i].id, vecs[i].perm, vecs[i].multi, vecs[i].irq,
                 vecs[i].ca, vecs[i].cb, vecs[i].cc}));
    end
    set_idle();

    // THRESH hits in one window make A permanent; later A hits only count.
    do_reset();
    for (int k = 0; k < TH - 1; k++) do_hit_ack(0);
    check("pre_perm", 32'(perm_fault), 32'd0);
    set_in(8'h20, '0, '0, 1'b0, 1'b0);
    tick();
    check("perm_set", 32'(perm_fault), 32'd1);
    check("perm_irq", 32'(irq), 32'd1);
    check("perm_req_open", 32'({resync_req, replica_id}), 32'({1'b1, 2'd0}));
    set_in('0, '0, '0, 1'b0, 1'b1);
    tick();
    set_idle();
    tick();
    tick();
    set_in(8'h01, '0, '0, 1'b0, 1'b0);
    tick();
    check("perm_cnt5", 32'(cnt_a), 32'd5);
    check("perm_no_req", 32'(resync_req), 32'd0);
    set_idle();
    tick();
    check("perm_no_req2", 32'(resync_req), 32'd0);

    // Window boundary: a hit on the wrap cycle belongs to the next window.
    do_reset();
    for (int k = 0; k < TH - 1; k++) do_hit_ack(0);
    while (m_cycle != WIN - 1) tick();
    do_hit_ack(0);
    check("wrap_no_perm", 32'(perm_fault), 32'd0);
    for (int k = 0; k < TH - 2; k++) do_hit_ack(0);
    check("win2_below", 32'(perm_fault), 32'd0);
    do_hit_ack(0);
    check("win2_perm", 32'(perm_fault), 32'd1);
    check("win2_cnt", 32'(cnt_a), 32'(2 * TH - 1));

    // Saturating counter with a stream of C hits; permanent C is not re-served.
    do_reset();
    set_in('0, '0, 8'h10, 1'b0, 1'b0);
    for (int i = 0; i < CMAX + 45; i++) tick();
    check("sat_cnt_c", 32'(cnt_c), 32'(CMAX));
    check("sat_perm_c", 32'(perm_fault), 32'd4);
    check("sat_req_c", 32'({resync_req, replica_id}), 32'({1'b1, 2'd2}));
    set_in('0, '0, '0, 1'b0, 1'b1);
    tick();
    set_idle();
    tick();
    tick();
    tick();
    check("sat_no_reissue", 32'(resync_req), 32'd0);

    // Reset in the middle of a handshake drops the request without an ack.
    do_reset();
    set_in('0, 8'h40, '0, 1'b0, 1'b0);
    tick();
    check("rst_req_up", 32'(resync_req), 32'd1);
    set_idle();
    rst = 1'b1;
    tick();
    check("rst_req_drop", 32'(dut_word()), 32'd0);
    rst = 1'b0;

    // Randomized traffic against the model.
    do_reset();
    rate = 10;
    for (int i = 0; i < 6000; i++) begin
      if ((i % 500) == 0) rate = $urandom_range(40, 2);
      err_a = '0; err_b = '0; err_c = '0;
      bitv = NV'(1) << $urandom_range(NV - 1, 0);
      if ($urandom_range(999, 0) < rate) err_a = bitv;
      bitv = NV'(1) << $urandom_range(NV - 1, 0);
      if ($urandom_range(999, 0) < rate) err_b = bitv;
      bitv = NV'(1) << $urandom_range(NV - 1, 0);
      if ($urandom_range(999, 0) < rate) err_c = bitv;
      clear = ($urandom_range(199, 0) == 0);
      ack   = m_req ? ($urandom_range(3, 0) == 0) : ($urandom_range(49, 0) == 0);
      tick();
    end
    set_idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
